// File: rtl/count_enable_ctrl.sv
// rtl/count_enable_ctrl.sv - pushbutton conditioning, run/stop FSM and en prescaler
// Optional single-step button path is built when SINGLE_STEP_EN is defined.
`timescale 1ns/1ps
module count_enable_ctrl #(
  parameter int DIV             = 10,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_run,
  input  logic btn_clr,
`ifdef SINGLE_STEP_EN
  input  logic btn_step,
`endif
  output logic en,
  output logic cnt_clr,
  output logic running
);

`ifdef SINGLE_STEP_EN
  localparam int NBTN = 3;
`else
  localparam int NBTN = 2;
`endif
  localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int PSW = (DIV > 1) ? $clog2(DIV) : 1;

  typedef enum logic {
    ST_STOPPED = 1'b0,
    ST_RUNNING = 1'b1
  } state_t;

  logic [NBTN-1:0] w_btn_raw;
  logic [NBTN-1:0] r_sync1;
  logic [NBTN-1:0] r_sync2;
  logic [NBTN-1:0] r_stable;
  logic [NBTN-1:0] r_stable_d;
  logic [NBTN-1:0] r_press;
  logic [DBW-1:0]  r_db_cnt [NBTN];

  state_t          r_state;
  state_t          w_state_nxt;
  logic [PSW-1:0]  r_pre;
  logic [PSW-1:0]  w_pre_nxt;
  logic            w_en_nxt;
  logic            r_en;
  logic            r_cnt_clr;
  logic            w_run_press;
  logic            w_clr_press;
  logic            w_step_press;

`ifdef SINGLE_STEP_EN
  assign w_btn_raw    = {btn_step, btn_clr, btn_run};
  assign w_step_press = r_press[2];
`else
  assign w_btn_raw    = {btn_clr, btn_run};
  assign w_step_press = 1'b0;
`endif
  assign w_run_press = r_press[0];
  assign w_clr_press = r_press[1];

  // Only r_sync2 feeds logic; r_sync1 is purely the metastability stage.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= w_btn_raw;
      r_sync2 <= r_sync1;
    end
  end

  // Stable value flips only after the synced input has differed for a full count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stable <= '0;
      for (int i = 0; i < NBTN; i++) begin
        r_db_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NBTN; i++) begin
        if (r_sync2[i] == r_stable[i]) begin
          r_db_cnt[i] <= '0;
        end else if (r_db_cnt[i] == DBW'(DEBOUNCE_CYCLES)) begin
          r_stable[i] <= r_sync2[i];
          r_db_cnt[i] <= '0;
        end else begin
          r_db_cnt[i] <= r_db_cnt[i] + DBW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stable_d <= '0;
      r_press    <= '0;
    end else begin
      r_stable_d <= r_stable;
      r_press    <= r_stable & ~r_stable_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_STOPPED;
      r_pre     <= '0;
      r_en      <= 1'b0;
      r_cnt_clr <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_pre     <= w_pre_nxt;
      r_en      <= w_en_nxt;
      r_cnt_clr <= w_clr_press;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pre_nxt   = r_pre;
    w_en_nxt    = 1'b0;

    if (w_run_press) begin
      w_state_nxt = (r_state == ST_STOPPED) ? ST_RUNNING : ST_STOPPED;
    end

    if (w_run_press || w_clr_press || (r_state == ST_STOPPED)) begin
      w_pre_nxt = '0;
    end else if (r_pre == PSW'(DIV - 1)) begin
      w_pre_nxt = '0;
    end else begin
      w_pre_nxt = r_pre + PSW'(1);
    end

    // A transition or clear restarts the cadence, so the tick due that cycle is dropped.
    if ((r_state == ST_RUNNING) && !w_run_press && !w_clr_press &&
        (r_pre == PSW'(DIV - 1))) begin
      w_en_nxt = 1'b1;
    end

    if ((r_state == ST_STOPPED) && w_step_press && !w_clr_press) begin
      w_en_nxt = 1'b1;
    end
  end

  assign en      = r_en;
  assign cnt_clr = r_cnt_clr;
  assign running = (r_state == ST_RUNNING);

endmodule

// File: tb/tb_count_enable_ctrl.sv
// tb/tb_count_enable_ctrl.sv - randomized and directed bench for count_enable_ctrl
`timescale 1ns/1ps
module tb_count_enable_ctrl;

  localparam int DIVP = 4;
  localparam int DEBP = 4;
  localparam int MAXE = 16384;
`ifdef SINGLE_STEP_EN
  localparam int NB = 3;
`else
  localparam int NB = 2;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [NB-1:0] btn = '0;
  logic          en;
  logic          cnt_clr;
  logic          running;

  int checks = 0;
  int failures = 0;
  int en_seen = 0;

  count_enable_ctrl #(.DIV(DIVP), .DEBOUNCE_CYCLES(DEBP)) dut (
    .clk     (clk),
    .reset   (reset),
    .btn_run (btn[0]),
    .btn_clr (btn[1]),
`ifdef SINGLE_STEP_EN
    .btn_step(btn[2]),
`endif
    .en      (en),
    .cnt_clr (cnt_clr),
    .running (running)
  );

  always #5 clk = ~clk;

  // Reference model: raw samples history per edge; a debounced level changes once
  // the synced view (raw delayed two edges) has disagreed for DEBP+1 edges in a row.
  bit hist [NB][MAXE];
  bit rise [NB][MAXE];
  bit m_stable [NB];
  int n = 0;
  int last_clr = 0;
  bit m_run = 1'b0;
  bit exp_en = 1'b0;
  bit exp_clr = 1'b0;

  initial forever begin
    @(posedge clk or posedge reset);
    if (reset) begin
      n = 0;
      last_clr = 0;
      m_run = 1'b0;
      exp_en = 1'b0;
      exp_clr = 1'b0;
      for (int b = 0; b < NB; b++) m_stable[b] = 1'b0;
    end else begin
      bit run_ev, clr_ev, step_ev;
      if (n >= MAXE) begin
        $display("FAIL model_capacity edges=%0d limit=%0d", n, MAXE);
        $fatal(1);
      end
      for (int b = 0; b < NB; b++) hist[b][n] = btn[b];
      for (int b = 0; b < NB; b++) begin
        bit all_diff;
        all_diff = 1'b1;
        for (int j = 0; j <= DEBP; j++) begin
          int idx;
          bit v;
          idx = n - 2 - j;
          v = (idx >= 0) ? hist[b][idx] : 1'b0;
          if (v == m_stable[b]) all_diff = 1'b0;
        end
        rise[b][n] = all_diff && !m_stable[b];
        if (all_diff) m_stable[b] = !m_stable[b];
      end
      run_ev  = (n >= 2) && rise[0][n-2];
      clr_ev  = (n >= 2) && rise[1][n-2];
      step_ev = (NB > 2) && (n >= 2) && rise[NB-1][n-2];
      exp_clr = clr_ev;
      exp_en  = 1'b0;
      if (m_run && !run_ev && !clr_ev && (n > last_clr) && ((n - last_clr) % DIVP == 0))
        exp_en = 1'b1;
      if (!m_run && step_ev && !clr_ev)
        exp_en = 1'b1;
      if (run_ev) begin
        m_run = !m_run;
        last_clr = n;
      end
      if (clr_ev) last_clr = n;
      n++;
    end
  end

  initial forever begin
    @(negedge clk);
    checks++;
    if (en !== exp_en || cnt_clr !== exp_clr || running !== m_run) begin
      failures++;
      $display("FAIL cycle_cmp t=%0t got en=%b clr=%b run=%b exp en=%b clr=%b run=%b",
               $time, en, cnt_clr, running, exp_en, exp_clr, m_run);
    end
    if (en === 1'b1) en_seen++;
  end

  task automatic check_int(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  task automatic press(input int b, input int hold, input int gap);
    btn[b] = 1'b1;
    repeat (hold) @(negedge clk);
    btn[b] = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  initial begin
    int run_k, en_k, en_cnt, clr_k, nxt_k, base;

    repeat (3) @(negedge clk);
    reset = 1'b0;

    // 1: idle
    base = en_seen;
    repeat (100) @(negedge clk);
    check_int("idle_en_count", en_seen - base, 0);
    check_int("idle_running", int'(running), 0);

    // 2: bouncing run button then a held press
    for (int i = 0; i < 3; i++) begin
      btn[0] = 1'b1; repeat (2) @(negedge clk);
      btn[0] = 1'b0; repeat (2) @(negedge clk);
    end
    check_int("bounce_ignored", int'(running), 0);
    btn[0] = 1'b1;
    run_k = 0; en_k = 0; en_cnt = 0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (running && run_k == 0) run_k = k;
      if (en) begin
        en_cnt++;
        if (en_k == 0) en_k = k;
      end
    end
    btn[0] = 1'b0;
    check_int("run_rise_edge", run_k, 9);
    check_int("first_en_edge", en_k, 13);
    check_int("en_count_window", en_cnt, 5);
    repeat (10) @(negedge clk);

    // 4: clear while running
    btn[1] = 1'b1;
    clr_k = 0;
    for (int k = 1; k <= 40 && clr_k == 0; k++) begin
      @(negedge clk);
      if (k == 6) btn[1] = 1'b0;
      if (cnt_clr) clr_k = k;
    end
    btn[1] = 1'b0;
    check_int("clr_edge", clr_k, 9);
    check_int("clr_en_low", int'(en), 0);
    check_int("clr_running", int'(running), 1);
    nxt_k = 0;
    for (int k = 1; k <= 20 && nxt_k == 0; k++) begin
      @(negedge clk);
      if (en) nxt_k = k;
    end
    check_int("en_after_clr", nxt_k, 4);
    repeat (10) @(negedge clk);

    // 3: short glitch ignored, full press stops
    press(0, 3, 15);
    check_int("glitch_running", int'(running), 1);
    press(0, 8, 15);
    check_int("stop_running", int'(running), 0);
    base = en_seen;
    repeat (20) @(negedge clk);
    check_int("stop_no_en", en_seen - base, 0);

    // 5: asynchronous reset mid-run
    press(0, 8, 20);
    check_int("rerun_running", int'(running), 1);
    @(posedge clk);
    #3 reset = 1'b1;
    #1;
    check_int("async_rst_running", int'(running), 0);
    check_int("async_rst_en", int'(en), 0);
    check_int("async_rst_clr", int'(cnt_clr), 0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    check_int("post_rst_stopped", int'(running), 0);

`ifdef SINGLE_STEP_EN
    // 6: single-step while stopped, then while running
    base = en_seen;
    for (int i = 0; i < 3; i++) press(2, 8, 15);
    check_int("step_en_count", en_seen - base, 3);
    press(0, 8, 20);
    press(2, 8, 20);
    press(0, 8, 20);
`endif

    // Randomized button activity checked by the model every cycle
    for (int i = 0; i < 300; i++) begin
      int b;
      b = $urandom_range(0, NB - 1);
      btn[b] = ~btn[b];
      repeat ($urandom_range(1, 14)) @(negedge clk);
    end
    btn = '0;
    repeat (30) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
